// File: rtl/mdu_exec.sv
// Multiply/divide execution unit: MUL_LAT-deep multiply pipeline plus a radix-2
// restoring divider, sharing a single registered HI/LO writeback port.
module mdu_exec #(
   parameter int DATA_W  = 32,
   parameter int PRF_W   = 6,
   parameter int ROB_W   = 6,
   parameter int MUL_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              issue_en,
   input  logic [1:0]        issue_op,
   input  logic [DATA_W-1:0] issue_src_a,
   input  logic [DATA_W-1:0] issue_src_b,
   input  logic [PRF_W-1:0]  issue_hi_prf,
   input  logic [PRF_W-1:0]  issue_lo_prf,
   input  logic [ROB_W-1:0]  issue_rob_id,
   output logic              mul_busy,
   output logic              div_busy,
   output logic              wb_valid,
   output logic [PRF_W-1:0]  wb_hi_prf,
   output logic [PRF_W-1:0]  wb_lo_prf,
   output logic [DATA_W-1:0] wb_hi_data,
   output logic [DATA_W-1:0] wb_lo_data,
   output logic [ROB_W-1:0]  wb_rob_id,
   output logic              wake_en,
   output logic [PRF_W-1:0]  wake_hi,
   output logic [PRF_W-1:0]  wake_lo
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} div_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic [PRF_W-1:0]  hi_prf;
      logic [PRF_W-1:0]  lo_prf;
      logic [ROB_W-1:0]  rob_id;
   } wb_pkt_t;

   logic op_signed, mul_acc, div_acc, div_wb, mul_last;
   logic [2*DATA_W-1:0] ext_a, ext_b, product;

   assign op_signed = ~issue_op[0];
   assign mul_acc   = issue_en && !issue_op[1] && !mul_busy && !flush;
   assign div_acc   = issue_en &&  issue_op[1] && !div_busy && !flush;

   // Sign-extending to 2*DATA_W makes one modular multiply serve MULT and MULTU.
   assign ext_a   = {{DATA_W{op_signed & issue_src_a[DATA_W-1]}}, issue_src_a};
   assign ext_b   = {{DATA_W{op_signed & issue_src_b[DATA_W-1]}}, issue_src_b};
   assign product = ext_a * ext_b;

   // ---------------- multiply pipeline ----------------
   logic [MUL_LAT-1:0] mul_vld;
   wb_pkt_t            mul_pkt [MUL_LAT];

   // NOTE: sequential state uses non-blocking (<=) so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_vld <= '0;
      end else if (flush) begin
         mul_vld <= '0;
      end else begin
         mul_vld[0] <= mul_acc;
         for (int i = 1; i < MUL_LAT; i++) mul_vld[i] <= mul_vld[i-1];
      end
   end

   // NOTE: payload storage is left unreset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      mul_pkt[0] <= '{hi: product[2*DATA_W-1:DATA_W], lo: product[DATA_W-1:0],
                      hi_prf: issue_hi_prf, lo_prf: issue_lo_prf, rob_id: issue_rob_id};
      for (int i = 1; i < MUL_LAT; i++) mul_pkt[i] <= mul_pkt[i-1];
   end

   assign mul_last = mul_vld[MUL_LAT-1];

   // ---------------- divider FSM ----------------
   div_state_t        state, state_nxt;
   logic [CNT_W-1:0]  div_cnt;
   logic [DATA_W-1:0] div_rem, div_quo, div_dsr, abs_a, abs_b;
   logic              neg_q, neg_r, div_zero;
   logic [PRF_W-1:0]  div_hi_prf, div_lo_prf;
   logic [ROB_W-1:0]  div_rob;
   logic [DATA_W:0]   shifted, diff;
   wb_pkt_t           div_pkt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (div_acc) state_nxt = S_CALC;
            S_CALC:  if (div_cnt == CNT_W'(DATA_W-1)) state_nxt = S_DONE;
            S_DONE:  if (!mul_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Holding off multiplies while DONE drains the pipe, so the divider wins the port within MUL_LAT cycles.
   always_comb begin
      div_busy = (state != S_IDLE);
      mul_busy = (state == S_DONE);
      div_wb   = (state == S_DONE) && !mul_last;
   end

   assign abs_a   = (op_signed && issue_src_a[DATA_W-1]) ? -issue_src_a : issue_src_a;
   assign abs_b   = (op_signed && issue_src_b[DATA_W-1]) ? -issue_src_b : issue_src_b;
   assign shifted = {div_rem, div_quo[DATA_W-1]};
   assign diff    = shifted - {1'b0, div_dsr};

   always_ff @(posedge clk) begin
      if (div_acc) begin
         div_rem    <= '0;
         div_quo    <= abs_a;
         div_dsr    <= abs_b;
         div_cnt    <= '0;
         neg_q      <= op_signed & (issue_src_a[DATA_W-1] ^ issue_src_b[DATA_W-1]);
         neg_r      <= op_signed & issue_src_a[DATA_W-1];
         div_zero   <= (issue_src_b == '0);
         div_hi_prf <= issue_hi_prf;
         div_lo_prf <= issue_lo_prf;
         div_rob    <= issue_rob_id;
      end else if (state == S_CALC) begin
         div_cnt <= div_cnt + CNT_W'(1);
         if (!diff[DATA_W]) begin
            div_rem <= diff[DATA_W-1:0];
            div_quo <= {div_quo[DATA_W-2:0], 1'b1};
         end else begin
            div_rem <= shifted[DATA_W-1:0];
            div_quo <= {div_quo[DATA_W-2:0], 1'b0};
         end
      end
   end

   // A zero divisor leaves rem=|a|, and the remainder sign fix restores a itself.
   assign div_pkt = '{hi:     neg_r ? -div_rem : div_rem,
                      lo:     div_zero ? '1 : (neg_q ? -div_quo : div_quo),
                      hi_prf: div_hi_prf, lo_prf: div_lo_prf, rob_id: div_rob};

   // ---------------- writeback port ----------------
   wb_pkt_t wb_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_q     <= '0;
      end else if (flush) begin
         wb_valid <= 1'b0;
      end else if (mul_last) begin
         wb_valid <= 1'b1;
         wb_q     <= mul_pkt[MUL_LAT-1];
      end else if (div_wb) begin
         wb_valid <= 1'b1;
         wb_q     <= div_pkt;
      end else begin
         wb_valid <= 1'b0;
      end
   end

   assign wb_hi_data = wb_q.hi;
   assign wb_lo_data = wb_q.lo;
   assign wb_hi_prf  = wb_q.hi_prf;
   assign wb_lo_prf  = wb_q.lo_prf;
   assign wb_rob_id  = wb_q.rob_id;
   assign wake_en    = wb_valid;
   assign wake_hi    = wb_q.hi_prf;
   assign wake_lo    = wb_q.lo_prf;

endmodule

// File: tb/tb_mdu_exec.sv
// Self-checking bench for mdu_exec: directed scenarios plus random traffic, compared
// cycle by cycle against a transaction-level model of completion times and results.
module tb_mdu_exec;
   localparam int DATA_W = 32, PRF_W = 6, ROB_W = 6, MUL_LAT = 3;

   logic              clk, rst, flush, issue_en;
   logic [1:0]        issue_op;
   logic [DATA_W-1:0] issue_src_a, issue_src_b;
   logic [PRF_W-1:0]  issue_hi_prf, issue_lo_prf;
   logic [ROB_W-1:0]  issue_rob_id;
   logic              mul_busy, div_busy, wb_valid, wake_en;
   logic [PRF_W-1:0]  wb_hi_prf, wb_lo_prf, wake_hi, wake_lo;
   logic [DATA_W-1:0] wb_hi_data, wb_lo_data;
   logic [ROB_W-1:0]  wb_rob_id;

   mdu_exec #(.DATA_W(DATA_W), .PRF_W(PRF_W), .ROB_W(ROB_W), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .issue_en(issue_en), .issue_op(issue_op),
      .issue_src_a(issue_src_a), .issue_src_b(issue_src_b), .issue_hi_prf(issue_hi_prf),
      .issue_lo_prf(issue_lo_prf), .issue_rob_id(issue_rob_id), .mul_busy(mul_busy),
      .div_busy(div_busy), .wb_valid(wb_valid), .wb_hi_prf(wb_hi_prf), .wb_lo_prf(wb_lo_prf),
      .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data), .wb_rob_id(wb_rob_id),
      .wake_en(wake_en), .wake_hi(wake_hi), .wake_lo(wake_lo));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned due;
      logic [31:0] hi, lo;
      logic [5:0]  hp, lp, rob;
   } rec_t;

   rec_t        mq[$];
   rec_t        cur, d_rec;
   bit          cur_v, d_act;
   int unsigned d_acc, cyc;
   int          n_vec, n_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
      end
   endtask

   // Reference results straight from the arithmetic definitions of each op.
   function automatic rec_t compute(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned due);
      rec_t r;
      int sa, sb;
      longint p;
      logic [63:0] u;
      sa = a; sb = b;
      r.due = due; r.hi = '0; r.lo = '0;
      r.hp = 6'($urandom); r.lp = 6'($urandom); r.rob = 6'($urandom);
      case (op)
         2'd0: begin p = longint'(sa) * longint'(sb); r.hi = p[63:32]; r.lo = p[31:0]; end
         2'd1: begin u = {32'b0, a} * {32'b0, b}; r.hi = u[63:32]; r.lo = u[31:0]; end
         2'd2: begin
            if (b == 0) begin r.lo = '1; r.hi = a; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r.lo = a; r.hi = 0; end
            else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
         end
         default: begin
            if (b == 0) begin r.lo = '1; r.hi = a; end
            else begin r.lo = a / b; r.hi = a % b; end
         end
      endcase
      return r;
   endfunction

   task automatic check_outputs();
      bit mb;
      mb = d_act && (cyc >= d_acc + 32);
      check("wb_valid", wb_valid, cur_v);
      check("wake_en", wake_en, cur_v);
      check("div_busy", div_busy, d_act);
      check("mul_busy", mul_busy, mb);
      if (cur_v) begin
         check("wb_hi_data", wb_hi_data, cur.hi);
         check("wb_lo_data", wb_lo_data, cur.lo);
         check("wb_hi_prf", wb_hi_prf, cur.hp);
         check("wb_lo_prf", wb_lo_prf, cur.lp);
         check("wb_rob_id", wb_rob_id, cur.rob);
         check("wake_hi", wake_hi, cur.hp);
         check("wake_lo", wake_lo, cur.lp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_wb_valid"}, wb_valid, 0);
      check({pfx, "_wb_hi_data"}, wb_hi_data, 0);
      check({pfx, "_wb_lo_data"}, wb_lo_data, 0);
      check({pfx, "_wb_hi_prf"}, wb_hi_prf, 0);
      check({pfx, "_wb_lo_prf"}, wb_lo_prf, 0);
      check({pfx, "_wb_rob_id"}, wb_rob_id, 0);
      check({pfx, "_wake"}, {wake_en, wake_hi, wake_lo}, 0);
      check({pfx, "_busy"}, {mul_busy, div_busy}, 0);
   endtask

   // One clock: check the current cycle, drive inputs, advance the model to the next edge.
   task automatic cycle(input bit en, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit fl);
      bit mb, db, nv;
      rec_t nr, ir;
      check_outputs();
      ir = compute(op, a, b, cyc + 1 + MUL_LAT);
      issue_en = en; issue_op = op; issue_src_a = a; issue_src_b = b; flush = fl;
      issue_hi_prf = ir.hp; issue_lo_prf = ir.lp; issue_rob_id = ir.rob;
      mb = d_act && (cyc >= d_acc + 32);
      db = d_act;
      nv = 1'b0;
      nr = cur;
      if (mq.size() > 0 && mq[0].due == cyc + 1) begin
         nr = mq.pop_front(); nv = 1'b1;
      end else if (d_act && cyc + 1 >= d_acc + 33) begin
         nr = d_rec; nv = 1'b1; d_act = 1'b0;
      end
      if (fl) begin
         nv = 1'b0; mq.delete(); d_act = 1'b0;
      end else if (en) begin
         if ((!op[1] && mb) || (op[1] && db))
            $display("protocol: issue of op %0d while busy at cyc %0d, expected to be ignored", op, cyc);
         else if (!op[1])
            mq.push_back(ir);
         else begin
            d_act = 1'b1; d_acc = cyc + 1; d_rec = ir;
         end
      end
      @(posedge clk);
      cyc++;
      cur = nr; cur_v = nv;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
   endtask

   task automatic reset_pulse();
      check_outputs();
      issue_en = 1'b0; flush = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      mq.delete(); d_act = 1'b0; cur_v = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'd0;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      n_vec = 0; n_err = 0; cyc = 0; cur_v = 0; d_act = 0; d_acc = 0;
      rst = 1'b1; flush = 1'b0; issue_en = 1'b0; issue_op = '0;
      issue_src_a = '0; issue_src_b = '0; issue_hi_prf = '0; issue_lo_prf = '0; issue_rob_id = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // MULT -2 x 3
      cycle(1, 2'd0, 32'hFFFF_FFFE, 32'd3, 0);
      idle(MUL_LAT + 2);
      // MULTU max x max, then four back-to-back MULTs
      cycle(1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      repeat (4) cycle(1, 2'd0, $urandom, $urandom, 0);
      idle(MUL_LAT + 3);
      // DIV -7/2 with an ignored DIVU issued mid-divide
      cycle(1, 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      idle(4);
      cycle(1, 2'd3, 32'd55, 32'd5, 0);
      idle(35);
      // divide by zero and signed overflow
      cycle(1, 2'd3, 32'd100, 32'd0, 0);
      idle(36);
      cycle(1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      idle(36);
      cycle(1, 2'd2, 32'hFFFF_FF00, 32'd0, 0);
      idle(36);
      // DIV contending with MULTs issued every cycle from edge 31
      cycle(1, 2'd2, $urandom, 32'($urandom_range(1, 1000)), 0);
      idle(30);
      repeat (8) cycle(1, 2'($urandom_range(0, 1)), $urandom, $urandom, 0);
      idle(10);
      // flush at edge 10 of a DIV with two MULTs in flight
      cycle(1, 2'd2, 32'd1000, 32'd7, 0);
      idle(7);
      cycle(1, 2'd0, 32'd5, 32'd6, 0);
      cycle(1, 2'd1, 32'd7, 32'd8, 0);
      cycle(1, 2'd0, 32'd9, 32'd9, 1);
      idle(8);
      // asynchronous reset mid-divide
      cycle(1, 2'd3, 32'd12345, 32'd11, 0);
      cycle(1, 2'd0, 32'd3, 32'd4, 0);
      idle(14);
      reset_pulse();
      idle(40);

      // random traffic that respects the busy back-pressure
      for (int i = 0; i < 700; i++) begin
         bit en, fl;
         logic [1:0] op;
         op = 2'($urandom_range(0, 3));
         en = ($urandom_range(0, 3) != 0);
         if (!op[1] && d_act && cyc >= d_acc + 32) en = 1'b0;
         if (op[1] && d_act) en = 1'b0;
         fl = ($urandom_range(0, 59) == 0);
         cycle(en, op, pick_operand(), pick_operand(), fl);
      end
      idle(45);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
